// File: rtl/ycbcr_pkg.sv
// rtl/ycbcr_pkg.sv - shared types and constants for the RGB to YCbCr converter
package ycbcr_pkg;

    typedef enum logic {
        CSC_FULL   = 1'b0,
        CSC_STUDIO = 1'b1
    } csc_mode_e;

    typedef logic signed [9:0] coef_t;

    // Q8 matrix, indexed [mode][channel Y/Cb/Cr][term R/G/B]
    localparam coef_t COEF [2][3][3] = '{
        '{ '{ 10'sd77,   10'sd150,  10'sd29  },
           '{ -10'sd43,  -10'sd85,  10'sd128 },
           '{ 10'sd128,  -10'sd107, -10'sd21 } },
        '{ '{ 10'sd66,   10'sd129,  10'sd25  },
           '{ -10'sd38,  -10'sd74,  10'sd112 },
           '{ 10'sd112,  -10'sd94,  -10'sd18 } }
    };

    localparam int ROUND = 128;
    localparam int FRAC  = 8;

endpackage

// File: rtl/csc_dot3.sv
// rtl/csc_dot3.sv - one output channel: 3-term MAC, round, offset and clamp
module csc_dot3
    import ycbcr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld2,
    input  logic              ld3,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] b,
    input  csc_mode_e         mode_s1,
    input  csc_mode_e         mode_s2,
    output logic [DATA_W-1:0] q
);

    localparam int ACC_W = DATA_W + 10;
    localparam logic signed [ACC_W-1:0] OFF_C = ACC_W'(1 << (DATA_W - 1));
    localparam logic signed [ACC_W-1:0] OFF_Y = ACC_W'(16 << (DATA_W - 8));
    localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'((1 << DATA_W) - 1);

    logic                    msel;
    logic signed [ACC_W-1:0] rs, gs, bs;
    logic signed [ACC_W-1:0] c0, c1, c2;
    logic signed [ACC_W-1:0] mac, acc, rnd, sh, off, sum;
    logic [DATA_W-1:0]       clip;

    assign msel = (mode_s1 == CSC_STUDIO);

    // Components are unsigned; widen with zeros so the signed product is correct
    assign rs = $signed({10'd0, r});
    assign gs = $signed({10'd0, g});
    assign bs = $signed({10'd0, b});

    assign c0 = ACC_W'(COEF[msel][CH][0]);
    assign c1 = ACC_W'(COEF[msel][CH][1]);
    assign c2 = ACC_W'(COEF[msel][CH][2]);

    assign mac = rs * c0 + gs * c1 + bs * c2;

    // Stage 2 register: raw dot product
    always_ff @(posedge clk) begin
        if (ld2) begin
            acc <= mac;
        end
    end

    // Arithmetic shift floors, so adding half an LSB first gives round-half-up
    assign rnd = acc + ACC_W'(ROUND);
    assign sh  = rnd >>> FRAC;
    assign off = (CH == 0) ? ((mode_s2 == CSC_STUDIO) ? OFF_Y : '0) : OFF_C;
    assign sum = sh + off;

    // Saturate into the unsigned output range
    always_comb begin
        clip = sum[DATA_W-1:0];
        if (sum[ACC_W-1]) begin
            clip = '0;
        end else if (sum > MAXV) begin
            clip = '1;
        end
    end

    // Stage 3 register: visible output, cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld3) begin
            q <= clip;
        end
    end

endmodule

// File: rtl/rgb2ycbcr_stream.sv
// rtl/rgb2ycbcr_stream.sv - 3-stage RGB to YCbCr stream converter with line counter
module rgb2ycbcr_stream
    import ycbcr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [DATA_W-1:0] out_cb,
    output logic [DATA_W-1:0] out_cr,
    output logic              out_last,
    output logic [CNT_W-1:0]  last_cnt
);

    logic              en;
    logic              v1, v2;
    logic              l1, l2;
    csc_mode_e         m1, m2;
    logic [DATA_W-1:0] r1, g1, b1;
    logic              ld2, ld3;

    // The whole pipeline advances together, so the only combinational path is out_ready -> in_ready
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign ld2      = en && v1;
    assign ld3      = en && v2;

    // Valid/last/counter pipeline, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            last_cnt  <= '0;
        end else begin
            if (en) begin
                v1        <= in_valid;
                v2        <= v1;
                out_valid <= v2;
            end
            if (ld3) begin
                out_last <= l2;
            end
            if (out_valid && out_ready && out_last) begin
                last_cnt <= last_cnt + 1'b1;
            end
        end
    end

    // Stage 1 and stage 2 sideband data; qualified by the valid bits, so no reset
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            r1 <= in_r;
            g1 <= in_g;
            b1 <= in_b;
            m1 <= csc_mode_e'(in_mode);
            l1 <= in_last;
        end
        if (ld2) begin
            m2 <= m1;
            l2 <= l1;
        end
    end

    csc_dot3 #(.DATA_W(DATA_W), .CH(0)) u_y (
        .clk(clk), .rst(rst), .ld2(ld2), .ld3(ld3),
        .r(r1), .g(g1), .b(b1), .mode_s1(m1), .mode_s2(m2), .q(out_y)
    );

    csc_dot3 #(.DATA_W(DATA_W), .CH(1)) u_cb (
        .clk(clk), .rst(rst), .ld2(ld2), .ld3(ld3),
        .r(r1), .g(g1), .b(b1), .mode_s1(m1), .mode_s2(m2), .q(out_cb)
    );

    csc_dot3 #(.DATA_W(DATA_W), .CH(2)) u_cr (
        .clk(clk), .rst(rst), .ld2(ld2), .ld3(ld3),
        .r(r1), .g(g1), .b(b1), .mode_s1(m1), .mode_s2(m2), .q(out_cr)
    );

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// tb/tb_rgb2ycbcr_stream.sv - directed self-checking bench for rgb2ycbcr_stream
module tb_rgb2ycbcr_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;

    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_y, out_cb, out_cr;
    logic [15:0] last_cnt;

    logic        in_ready2, out_valid2, out_last2;
    logic [7:0]  out_y2, out_cb2, out_cr2;
    logic [1:0]  last_cnt2;

    int passed = 0;
    int total  = 0;

    logic [7:0]  vr [8];
    logic [7:0]  vg [8];
    logic [7:0]  vb [8];
    logic        vm [8];
    logic [23:0] vexp [8];

    int   sidx  [16];
    logic slast [16];

    always #5 clk = ~clk;

    rgb2ycbcr_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
        .out_last(out_last), .last_cnt(last_cnt)
    );

    rgb2ycbcr_stream #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_y(out_y2), .out_cb(out_cb2), .out_cr(out_cr2),
        .out_last(out_last2), .last_cnt(last_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int i, input logic last);
        in_r    = vr[i];
        in_g    = vg[i];
        in_b    = vb[i];
        in_mode = vm[i];
        in_last = last;
    endtask

    task automatic single(input string tag, input int i);
        int lat;
        out_ready = 1'b1;
        drive_pix(i, 1'b0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cyc();
            lat = lat + 1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk(tag, 64'({out_y, out_cb, out_cr}), 64'(vexp[i]));
        cyc();
    endtask

    task automatic stream(input string tag, input logic [15:0] pat, input int n, output int cycles);
        int sent;
        int got;
        int c;
        logic [15:0] p;
        sent = 0;
        got  = 0;
        c    = 0;
        p    = pat;
        while (got < n && c < 200) begin
            out_ready = p[c % 16];
            in_valid  = (sent < n);
            if (sent < n) drive_pix(sidx[sent], slast[sent]);
            #1;
            if (out_valid && !out_ready) chk({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
            if (out_valid && got < n)
                chk({tag, "_data"}, 64'({out_y, out_cb, out_cr, out_last}), 64'({vexp[sidx[got]], slast[got]}));
            if (out_valid2 && got < n)
                chk({tag, "_data2"}, 64'({out_y2, out_cb2, out_cr2, out_last2}), 64'({vexp[sidx[got]], slast[got]}));
            if (out_valid && out_ready) got = got + 1;
            if (in_valid && in_ready) sent = sent + 1;
            c = c + 1;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
        cycles = c;
    endtask

    initial begin
        int cycles;

        vr[0] = 8'd0;   vg[0] = 8'd0;   vb[0] = 8'd0;   vm[0] = 1'b0; vexp[0] = {8'd0,   8'd128, 8'd128};
        vr[1] = 8'd255; vg[1] = 8'd255; vb[1] = 8'd255; vm[1] = 1'b0; vexp[1] = {8'd255, 8'd128, 8'd128};
        vr[2] = 8'd255; vg[2] = 8'd0;   vb[2] = 8'd0;   vm[2] = 1'b0; vexp[2] = {8'd77,  8'd85,  8'd255};
        vr[3] = 8'd123; vg[3] = 8'd88;  vb[3] = 8'd60;  vm[3] = 1'b0; vexp[3] = {8'd95,  8'd108, 8'd148};
        vr[4] = 8'd0;   vg[4] = 8'd0;   vb[4] = 8'd0;   vm[4] = 1'b1; vexp[4] = {8'd16,  8'd128, 8'd128};
        vr[5] = 8'd255; vg[5] = 8'd255; vb[5] = 8'd255; vm[5] = 1'b1; vexp[5] = {8'd235, 8'd128, 8'd128};
        vr[6] = 8'd255; vg[6] = 8'd0;   vb[6] = 8'd0;   vm[6] = 1'b1; vexp[6] = {8'd82,  8'd90,  8'd240};
        vr[7] = 8'd123; vg[7] = 8'd88;  vb[7] = 8'd60;  vm[7] = 1'b1; vexp[7] = {8'd98,  8'd111, 8'd145};

        // Reset state
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'({out_y, out_cb, out_cr, out_last}), 64'd0);
        chk("rst_cnt",   64'(last_cnt), 64'd0);
        chk("rst_cnt2",  64'(last_cnt2), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        cyc();
        rst = 1'b1;
        cyc();

        // Single pixels, both modes, with latency
        single("full_black", 0);
        single("full_white", 1);
        single("full_red",   2);
        single("full_mix",   3);
        single("stu_black",  4);
        single("stu_white",  5);
        single("stu_red",    6);
        single("stu_mix",    7);

        // Alternating mode, full throughput
        sidx[0] = 0; sidx[1] = 4; sidx[2] = 1; sidx[3] = 5;
        sidx[4] = 2; sidx[5] = 6; sidx[6] = 3; sidx[7] = 7;
        for (int i = 0; i < 16; i++) slast[i] = 1'b0;
        stream("alt", 16'hFFFF, 8, cycles);
        chk("alt_cycles", 64'(cycles), 64'd11);

        // Back-pressure
        sidx[0] = 3; sidx[1] = 7; sidx[2] = 2; sidx[3] = 6;
        sidx[4] = 1; sidx[5] = 5; sidx[6] = 0; sidx[7] = 4;
        stream("bp", 16'b1011_0010_1101_0110, 8, cycles);
        cyc();
        cyc();
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("cnt_zero", 64'(last_cnt), 64'd0);

        // Three lines of four pixels
        for (int i = 0; i < 16; i++) begin
            sidx[i]  = i % 8;
            slast[i] = ((i % 4) == 3);
        end
        stream("lines3", 16'hFFFF, 12, cycles);
        chk("cnt_3",  64'(last_cnt),  64'd3);
        chk("cnt2_3", 64'(last_cnt2), 64'd3);

        // Two more lines; the 2-bit counter wraps
        stream("lines2", 16'b0110_1101_1011_1110, 8, cycles);
        chk("cnt_5",  64'(last_cnt),  64'd5);
        chk("cnt2_1", 64'(last_cnt2), 64'd1);

        // Reset with a pixel at the output and two more in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_pix(3, 1'b1); cyc();
        drive_pix(7, 1'b1); cyc();
        drive_pix(2, 1'b1); cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt",   64'(last_cnt), 64'd0);
        chk("mid_rst_data",  64'({out_y, out_cb, out_cr, out_last}), 64'd0);
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        single("post_rst", 6);
        chk("post_rst_cnt", 64'(last_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rgb2ycbcr_stream.md
Name: rgb2ycbcr_stream

Overview:
- Next-generation colour-space converter: RGB pixel stream in, YCbCr pixel stream out.
- Parametrised component width; per-pixel selectable full-range (JPEG) or studio-range (BT.601) matrix.
- 3-stage pipeline with valid/ready flow control and back-pressure; end-of-line flag passes through.
- Adds a frame/line transfer counter. Sits between the pixel source (ROM/camera) and downstream image blocks.

Parameters:
- DATA_W, 8, bits per colour component in and out; must be >= 8.
- CNT_W, 16, width of the out_last transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_r, in_g, in_b  in  DATA_W each  unsigned RGB components.
- in_mode  in  1  0 = full range, 1 = studio range; sampled with the pixel.
- in_last  in  1  last pixel of line; travels with the pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_y, out_cb, out_cr  out  DATA_W each  unsigned YCbCr components.
- out_last  out  1  delayed in_last.
- last_cnt  out  CNT_W  count of completed output transfers with out_last=1.

Behaviour:
- Reset (rst=0, async): all stage valid bits 0; out_valid=0; out_y/out_cb/out_cr/out_last=0; last_cnt=0. Data registers need not be reset, except the output registers.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en. Combinational path is out_ready -> in_ready only. When en=0, all stages hold.
- Latency: exactly 3 clk from input transfer to out_valid, with out_ready held high. Throughput is 1 pixel/clk. No pixel is dropped or duplicated under any ready pattern.
- S1: register R, G, B, mode and last.
- S2: compute three signed dot products with Q8 coefficients. Accumulator width is DATA_W+10 bits, signed.
  - Full range (mode 0): Y = 77R+150G+29B; Cb = -43R-85G+128B; Cr = 128R-107G-21B.
  - Studio range (mode 1): Y = 66R+129G+25B; Cb = -38R-74G+112B; Cr = 112R-94G-18B.
- S3: add rounding constant 128, then arithmetic shift right by 8 (floor). Then add an offset:
  - Y offset: 0 (mode 0) or 16<<(DATA_W-8) (mode 1).
  - Cb/Cr offset: 1<<(DATA_W-1).
  - Clamp the result to [0, 2^DATA_W-1].
- Mode is per-pixel: consecutive pixels with different modes convert correctly with no bubble.
- last_cnt increments by 1 on each output transfer with out_last=1. It wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-stream: all in-flight pixels are discarded and all outputs return to their reset values immediately. The first pixel after reset release appears 3 cycles after its transfer.
- out_* data must be stable while out_valid=1 and out_ready=0.

Decomposition:
- Package ycbcr_pkg:
  - csc_mode_e enum (CSC_FULL, CSC_STUDIO).
  - Coefficient constants as a per-mode 3x3 signed array.
  - Constants ROUND=128, FRAC=8.
- Sub-module csc_dot3: one channel's 3-term signed multiply-accumulate plus round/shift/offset/clamp, parametrised by DATA_W. Instantiated 3 times.
- The top handles the handshake, the valid/last pipeline and last_cnt.

Test Plan:
- Full range, DATA_W=8, ready=1: (0,0,0) -> Y=0, Cb=128, Cr=128. (255,255,255) -> 255,128,128. Each appears 3 clk after input.
- Full range: (255,0,0) -> Y=77, Cb=85, Cr=255 (clamped from 256). (123,88,60) -> 95,108,148.
- Studio range: (0,0,0) -> 16,128,128. (255,255,255) -> 235,128,128. Alternate mode on every pixel -> each pixel matches its own mode.
- Back-pressure: stream 8 pixels, toggle out_ready with a pseudo-random pattern -> output order and values match the model; data stable while stalled; in_ready low whenever out_valid && !out_ready.
- last/counter: 3 lines of 4 pixels with in_last on every 4th -> out_last aligned with pixels 4, 8, 12; last_cnt=3. With CNT_W=2, 5 lines -> last_cnt=1 (wrap).
- Reset mid-stream: drop rst for 1 clk with 2 pixels in flight -> out_valid=0 and last_cnt=0 immediately; the next pixel emerges 3 clk after its transfer with correct values.
